// File: rtl/dmem_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_initiator : MEM-stage load/store initiator for a fixed-latency data memory
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_initiator #(
  parameter int WORD_LEN    = 32,
  parameter int MEM_LATENCY = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memReadEn,
  input  logic                memWriteEn,
  input  logic [WORD_LEN-1:0] address,
  input  logic [WORD_LEN-1:0] writeData,
  output logic [WORD_LEN-1:0] readData,
  output logic                freeze,
  output logic                accessErr,
  output logic [WORD_LEN-1:0] dmAddress,
  output logic [WORD_LEN-1:0] dmDataOut,
  input  logic [WORD_LEN-1:0] dmDataIn,
  output logic                dmReadEn,
  output logic                dmWriteEn
);

  localparam int                  CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(MEM_LATENCY - 1);
  localparam logic [WORD_LEN-1:0] BASE     = WORD_LEN'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wd_q, wd_d;
  logic [WORD_LEN-1:0] rd_q, rd_d;
  logic                is_write_q, is_write_d;

  logic                req;
  logic                mapped;
  logic                freeze_c, err_c, rden_c, wren_c;
  logic [WORD_LEN-1:0] rdata_c, daddr_c, dout_c;

  assign req    = memReadEn | memWriteEn;
  // Compare against the full byte address, before word alignment
  assign mapped = (address >= BASE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      rd_q       <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      rd_q       <= rd_d;
      is_write_q <= is_write_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    rd_d       = rd_q;
    is_write_d = is_write_q;
    freeze_c   = 1'b0;
    err_c      = 1'b0;
    rden_c     = 1'b0;
    wren_c     = 1'b0;
    rdata_c    = '0;
    daddr_c    = '0;
    dout_c     = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (mapped) begin
            freeze_c   = 1'b1;
            err_c      = memReadEn & memWriteEn;
            addr_d     = {address[WORD_LEN-1:2], 2'b00};
            wd_d       = writeData;
            is_write_d = memWriteEn;
            cnt_d      = CNT_INIT;
            state_d    = ACCESS;
          end else begin
            err_c = 1'b1;
          end
        end
      end

      ACCESS: begin
        freeze_c = 1'b1;
        daddr_c  = addr_q;
        dout_c   = wd_q;
        rden_c   = ~is_write_q;
        // One write strobe per store, in the last access cycle
        wren_c   = is_write_q && (cnt_q == '0);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!is_write_q) begin
            rd_d = dmDataIn;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        rdata_c = is_write_q ? '0 : rd_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign freeze    = rst & freeze_c;
  assign accessErr = rst & err_c;
  assign dmReadEn  = rst & rden_c;
  assign dmWriteEn = rst & wren_c;
  assign readData  = rst ? rdata_c : '0;
  assign dmAddress = rst ? daddr_c : '0;
  assign dmDataOut = rst ? dout_c  : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_initiator : vector/scoreboard bench, MEM_LATENCY=2 and MEM_LATENCY=1 instances
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dmem_initiator;

  localparam int W = 32;

  typedef struct packed {
    logic         freeze;
    logic         rden;
    logic         wren;
    logic         err;
    logic [W-1:0] rdata;
    logic [W-1:0] daddr;
    logic [W-1:0] dout;
  } exp_t;

  typedef struct packed {
    logic         rst;
    logic         rd;
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] din;
  } in_t;

  typedef struct {
    in_t  in;
    exp_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t in0 = '0;
  in_t in1 = '0;

  logic [W-1:0] rdata0, daddr0, dout0, rdata1, daddr1, dout1;
  logic         fz0, err0, re0, we0, fz1, err1, re1, we1;
  exp_t         act0, act1;

  assign act0 = {fz0, re0, we0, err0, rdata0, daddr0, dout0};
  assign act1 = {fz1, re1, we1, err1, rdata1, daddr1, dout1};

  dmem_initiator #(.WORD_LEN(W), .MEM_LATENCY(2), .BASE_ADDR(1024)) dut0 (
    .clk(clk), .rst(in0.rst), .memReadEn(in0.rd), .memWriteEn(in0.wr),
    .address(in0.addr), .writeData(in0.wdata), .readData(rdata0),
    .freeze(fz0), .accessErr(err0), .dmAddress(daddr0), .dmDataOut(dout0),
    .dmDataIn(in0.din), .dmReadEn(re0), .dmWriteEn(we0)
  );

  dmem_initiator #(.WORD_LEN(W), .MEM_LATENCY(1), .BASE_ADDR(1024)) dut1 (
    .clk(clk), .rst(in1.rst), .memReadEn(in1.rd), .memWriteEn(in1.wr),
    .address(in1.addr), .writeData(in1.wdata), .readData(rdata1),
    .freeze(fz1), .accessErr(err1), .dmAddress(daddr1), .dmDataOut(dout1),
    .dmDataIn(in1.din), .dmReadEn(re1), .dmWriteEn(we1)
  );

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // ctl = {rst, rd, wr}; flg = {freeze, dmReadEn, dmWriteEn, accessErr}
  function automatic vec_t mk(input logic [2:0] ctl, input logic [W-1:0] addr,
                              input logic [W-1:0] wdata, input logic [W-1:0] din,
                              input logic [3:0] flg, input logic [W-1:0] rdata,
                              input logic [W-1:0] daddr, input logic [W-1:0] dout);
    vec_t v;
    v.in  = {ctl, addr, wdata, din};
    v.exp = {flg, rdata, daddr, dout};
    return v;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("fz=%b re=%b we=%b err=%b rdata=%h addr=%h dout=%h",
                     e.freeze, e.rden, e.wren, e.err, e.rdata, e.daddr, e.dout);
  endfunction

  task automatic run(input int sel, input vec_t v, input string name, input int idx);
    exp_t e;
    exp_t a;
    @(posedge clk);
    #1;
    if (sel == 0) in0 = v.in;
    else          in1 = v.in;
    sb.push_back(v.exp);
    @(negedge clk);
    e = sb.pop_front();
    a = (sel == 0) ? act0 : act1;
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s[%0d] actual %s required %s", name, idx, fmt(a), fmt(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    vec_t seq[$];

    // reset, including gating of requests that arrive during reset
    tbl.push_back(mk(3'b000, 32'h0,   32'h0, 32'h0,        4'b0000, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(3'b010, 32'h404, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(3'b011, 32'h100, 32'h0, 32'h0,        4'b0000, 32'h0, 32'h0, 32'h0));
    // load 0x404
    tbl.push_back(mk(3'b110, 32'h404, 32'h0, 32'hDEADBEEF, 4'b1000, 32'h0, 32'h0,   32'h0));
    tbl.push_back(mk(3'b110, 32'h404, 32'h0, 32'hDEADBEEF, 4'b1100, 32'h0, 32'h404, 32'h0));
    tbl.push_back(mk(3'b110, 32'h404, 32'h0, 32'hDEADBEEF, 4'b1100, 32'h0, 32'h404, 32'h0));
    tbl.push_back(mk(3'b110, 32'h404, 32'h0, 32'h0,        4'b0000, 32'hDEADBEEF, 32'h0, 32'h0));
    tbl.push_back(mk(3'b100, 32'h0,   32'h0, 32'h0,        4'b0000, 32'h0, 32'h0,   32'h0));
    // store 0x12345678 at 0x40B; later writeData changes must not leak through
    tbl.push_back(mk(3'b101, 32'h40B, 32'h12345678, 32'h0,    4'b1000, 32'h0, 32'h0,   32'h0));
    tbl.push_back(mk(3'b101, 32'h40B, 32'hFFFFFFFF, 32'h0,    4'b1000, 32'h0, 32'h408, 32'h12345678));
    tbl.push_back(mk(3'b101, 32'h40B, 32'hFFFFFFFF, 32'h0,    4'b1010, 32'h0, 32'h408, 32'h12345678));
    tbl.push_back(mk(3'b101, 32'h40B, 32'hFFFFFFFF, 32'h5555, 4'b0000, 32'h0, 32'h0,   32'h0));
    tbl.push_back(mk(3'b100, 32'h0,   32'h0,        32'h0,    4'b0000, 32'h0, 32'h0,   32'h0));
    // unmapped accesses just below the base
    tbl.push_back(mk(3'b110, 32'h3FC, 32'h0, 32'h77, 4'b0001, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(3'b101, 32'h3FF, 32'h1, 32'h0,  4'b0001, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(3'b100, 32'h0,   32'h0, 32'h0,  4'b0000, 32'h0, 32'h0, 32'h0));
    // both enables at 0x500: write wins, error pulses in IDLE
    tbl.push_back(mk(3'b111, 32'h500, 32'hCAFEF00D, 32'h0,  4'b1001, 32'h0, 32'h0,   32'h0));
    tbl.push_back(mk(3'b111, 32'h500, 32'hCAFEF00D, 32'h0,  4'b1000, 32'h0, 32'h500, 32'hCAFEF00D));
    tbl.push_back(mk(3'b111, 32'h500, 32'hCAFEF00D, 32'h0,  4'b1010, 32'h0, 32'h500, 32'hCAFEF00D));
    tbl.push_back(mk(3'b111, 32'h500, 32'hCAFEF00D, 32'h99, 4'b0000, 32'h0, 32'h0,   32'h0));
    // load 0x7FF, immediately followed by a store accepted after DONE
    tbl.push_back(mk(3'b110, 32'h7FF, 32'h11111111, 32'h0,        4'b1000, 32'h0, 32'h0,   32'h0));
    tbl.push_back(mk(3'b110, 32'h7FF, 32'h11111111, 32'h0,        4'b1100, 32'h0, 32'h7FC, 32'h11111111));
    tbl.push_back(mk(3'b110, 32'h7FF, 32'h11111111, 32'h0BADF00D, 4'b1100, 32'h0, 32'h7FC, 32'h11111111));
    tbl.push_back(mk(3'b110, 32'h7FF, 32'h11111111, 32'h0,        4'b0000, 32'h0BADF00D, 32'h0, 32'h0));
    tbl.push_back(mk(3'b101, 32'h404, 32'h55AA55AA, 32'h0,        4'b1000, 32'h0, 32'h0,   32'h0));
    tbl.push_back(mk(3'b101, 32'h404, 32'h55AA55AA, 32'h0,        4'b1000, 32'h0, 32'h404, 32'h55AA55AA));
    // reset in the final ACCESS cycle aborts the store
    tbl.push_back(mk(3'b001, 32'h404, 32'h55AA55AA, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(3'b100, 32'h0,   32'h0,        32'h0, 4'b0000, 32'h0, 32'h0, 32'h0));
    // load exactly at the base address
    tbl.push_back(mk(3'b110, 32'h400, 32'h0, 32'h0,        4'b1000, 32'h0, 32'h0,   32'h0));
    tbl.push_back(mk(3'b110, 32'h400, 32'h0, 32'h0,        4'b1100, 32'h0, 32'h400, 32'h0));
    tbl.push_back(mk(3'b110, 32'h400, 32'h0, 32'h00C0FFEE, 4'b1100, 32'h0, 32'h400, 32'h0));
    tbl.push_back(mk(3'b100, 32'h0,   32'h0, 32'h0,        4'b0000, 32'h00C0FFEE, 32'h0, 32'h0));
    tbl.push_back(mk(3'b100, 32'h0,   32'h0, 32'h0,        4'b0000, 32'h0, 32'h0,   32'h0));

    foreach (tbl[i]) run(0, tbl[i], "lat2", i);

    // MEM_LATENCY=1: two back-to-back loads
    seq.push_back(mk(3'b000, 32'h0,   32'h0, 32'h0,        4'b0000, 32'h0, 32'h0,   32'h0));
    seq.push_back(mk(3'b110, 32'h404, 32'h0, 32'h0,        4'b1000, 32'h0, 32'h0,   32'h0));
    seq.push_back(mk(3'b110, 32'h404, 32'h0, 32'h11112222, 4'b1100, 32'h0, 32'h404, 32'h0));
    seq.push_back(mk(3'b110, 32'h404, 32'h0, 32'h0,        4'b0000, 32'h11112222, 32'h0, 32'h0));
    seq.push_back(mk(3'b110, 32'h408, 32'h0, 32'h0,        4'b1000, 32'h0, 32'h0,   32'h0));
    seq.push_back(mk(3'b110, 32'h408, 32'h0, 32'h33334444, 4'b1100, 32'h0, 32'h408, 32'h0));
    seq.push_back(mk(3'b100, 32'h0,   32'h0, 32'h0,        4'b0000, 32'h33334444, 32'h0, 32'h0));
    seq.push_back(mk(3'b100, 32'h0,   32'h0, 32'h0,        4'b0000, 32'h0, 32'h0,   32'h0));

    foreach (seq[i]) run(1, seq[i], "lat1", i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_initiator.md
Name: dmem_initiator

Overview:
- MEM-stage bus initiator that turns pipeline load/store requests into word accesses on the data-memory port.
- Models a memory with MEM_LATENCY cycles of access time and freezes the pipeline for the duration of each access.
- Aligns each address to a word boundary and filters out unmapped addresses below BASE_ADDR.
- Returns load data to the MEM/WB path.

Parameters:
- WORD_LEN, 32, data and address width.
- MEM_LATENCY, 2, number of ACCESS cycles per mapped access; must be at least 1.
- BASE_ADDR, 1024, lowest mapped byte address; requests below it are unmapped.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- memReadEn  in  1  load request from the MEM stage.
- memWriteEn  in  1  store request from the MEM stage.
- address  in  WORD_LEN  byte address from the ALU result.
- writeData  in  WORD_LEN  store data.
- readData  out  WORD_LEN  load result to MEM/WB.
- freeze  out  1  pipeline hold, active high.
- accessErr  out  1  single-cycle error flag.
- dmAddress  out  WORD_LEN  word-aligned address to the data memory.
- dmDataOut  out  WORD_LEN  data to the memory's write-data input.
- dmDataIn  in  WORD_LEN  data from the memory's read-data output.
- dmReadEn  out  1  memory read enable.
- dmWriteEn  out  1  memory write strobe.

Behaviour:
- Reset: while rst=0 at a clock edge, the block enters IDLE and clears the counter and the captured address, data and read registers.
- Reset gating: while rst=0, freeze, dmReadEn, dmWriteEn and accessErr are forced to 0, and readData and dmAddress read 0.
- States are IDLE, ACCESS and DONE.
- req = memReadEn | memWriteEn.
- isWrite = memWriteEn. A write takes priority when both enables are high.
- IDLE, req with address >= BASE_ADDR:
  - freeze=1 in the same cycle (combinational).
  - On the edge, capture addrReg = address & ~3, wdReg = writeData and isWrite.
  - Load cnt = MEM_LATENCY-1 and move to ACCESS.
- IDLE, req with address < BASE_ADDR:
  - No memory strobes and freeze=0.
  - accessErr=1 for this cycle and readData=0.
  - State stays IDLE.
- IDLE with memReadEn=1 and memWriteEn=1 at a mapped address: the access proceeds as a write, and accessErr=1 in the IDLE cycle.
- ACCESS:
  - freeze=1.
  - dmAddress=addrReg and dmDataOut=wdReg.
  - dmReadEn=1 in every ACCESS cycle of a read.
  - dmWriteEn=1 only in the final ACCESS cycle (cnt==0) of a write, giving exactly one write strobe per store.
  - While cnt>0: decrement cnt.
  - At cnt==0: latch rdReg=dmDataIn for a read and move to DONE.
- DONE:
  - freeze=0, no memory strobes.
  - readData = rdReg for a read, 0 for a write.
  - Input enables are ignored; they still belong to the same instruction, which leaves the stage at this edge.
  - Next state is IDLE unconditionally.
- readData is 0 in every state except DONE after a read.
- dmAddress and dmDataOut are 0 outside ACCESS.
- Latency: a mapped request holds freeze high for MEM_LATENCY+1 cycles (the IDLE cycle plus the ACCESS cycles). Load data appears in the following DONE cycle.
- Back-to-back requests: IDLE accepts the next request in the cycle after DONE, with no bubble beyond DONE.
- Reset mid-access: the access is aborted. If rst=0 in the final ACCESS cycle, no write strobe is issued, and the state is IDLE afterwards.
- Address arithmetic: the low 2 bits of address are dropped, so no misaligned-access error exists. The BASE_ADDR compare uses the unmasked address.

Test Plan:
- Reset, then a load at 0x404 with the memory returning 0xDEADBEEF: freeze high for 3 cycles, dmAddress=0x404, dmReadEn high for 2 cycles, readData=0xDEADBEEF in DONE, then 0.
- Store of 0x12345678 at 0x40B: dmAddress=0x408, dmWriteEn high for exactly 1 cycle (the 2nd ACCESS cycle), dmDataOut=0x12345678, freeze high for 3 cycles.
- Load at 0x3FC (unmapped): freeze=0, accessErr=1 for one cycle, readData=0, no dm strobes.
- memReadEn=memWriteEn=1 at 0x500: a single write strobe is issued and accessErr pulses in the IDLE cycle.
- rst driven low in the final ACCESS cycle of a store: no dmWriteEn pulse, state IDLE, and freeze=0 next cycle.
- Two consecutive loads with MEM_LATENCY=1: each freezes 2 cycles, the DONE cycles are separated, and the second request is accepted in the cycle after the first DONE.
